comparator_arbiter: RTL and testbench



---
 rtl/comparator_arbiter.sv | 155 +++++++++++++++
 tb/tb_comparator_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/comparator_arbiter.sv
// Round-robin arbiter time-sharing one magnitude comparator between N_REQ requesters.
// Define ARB_FIXED_PRIORITY_EN for fixed lowest-index-wins priority instead of round-robin.

module parameterized_comparator #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             lt_o,
   output logic             eq_o,
   output logic             gt_o
);
   assign lt_o = (a_i <  b_i);
   assign eq_o = (a_i == b_i);
   assign gt_o = (a_i >  b_i);
endmodule

// Handshake: requester i holds req[i] and its operands until done=1 with grant[i]=1;
// operands are captured on the grant edge, so req may drop or operands change afterwards.
module comparator_arbiter #(
   parameter int WIDTH = 16,
   parameter int N_REQ = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*WIDTH-1:0] a_flat,
   input  logic [N_REQ*WIDTH-1:0] b_flat,
   output logic [N_REQ-1:0]       grant,
   output logic                   done,
   output logic                   lt,
   output logic                   eq,
   output logic                   gt,
   output logic                   busy,
   output logic [1:0]             dbg_state_o
);
   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CMP  = 2'd1,
      S_RES  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [PTR_W-1:0] win_q, win_d;
   logic [WIDTH-1:0] op_a_q, op_a_d;
   logic [WIDTH-1:0] op_b_q, op_b_d;
   logic             lt_q, lt_d, eq_q, eq_d, gt_q, gt_d;
   logic             cmp_lt, cmp_eq, cmp_gt;
   logic             found;
   logic [PTR_W-1:0] pick;
   int unsigned      search_idx;
`ifndef ARB_FIXED_PRIORITY_EN
   logic [PTR_W-1:0] ptr_q, ptr_d;
`endif

   parameterized_comparator #(.WIDTH(WIDTH)) u_cmp (
      .a_i  (op_a_q),
      .b_i  (op_b_q),
      .lt_o (cmp_lt),
      .eq_o (cmp_eq),
      .gt_o (cmp_gt)
   );

   // First asserted request, scanning upward from the priority start and wrapping.
   always_comb begin
      found      = 1'b0;
      pick       = '0;
      search_idx = 0;
      for (int k = 0; k < N_REQ; k++) begin
`ifdef ARB_FIXED_PRIORITY_EN
         search_idx = k;
`else
         search_idx = (int'(ptr_q) + k) % N_REQ;
`endif
         if (!found && req[search_idx]) begin
            found = 1'b1;
            pick  = PTR_W'(search_idx);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      op_a_d  = op_a_q;
      op_b_d  = op_b_q;
      lt_d    = lt_q;
      eq_d    = eq_q;
      gt_d    = gt_q;
`ifndef ARB_FIXED_PRIORITY_EN
      ptr_d   = ptr_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (found) begin
               win_d   = pick;
               op_a_d  = a_flat[int'(pick)*WIDTH +: WIDTH];
               op_b_d  = b_flat[int'(pick)*WIDTH +: WIDTH];
               state_d = S_CMP;
            end
         end
         S_CMP: begin
            lt_d    = cmp_lt;
            eq_d    = cmp_eq;
            gt_d    = cmp_gt;
            state_d = S_RES;
         end
         S_RES: begin
`ifndef ARB_FIXED_PRIORITY_EN
            ptr_d = (win_q == PTR_W'(N_REQ - 1)) ? '0 : win_q + 1'b1;
`endif
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         win_q   <= '0;
         op_a_q  <= '0;
         op_b_q  <= '0;
         lt_q    <= 1'b0;
         eq_q    <= 1'b0;
         gt_q    <= 1'b0;
`ifndef ARB_FIXED_PRIORITY_EN
         ptr_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
         op_a_q  <= op_a_d;
         op_b_q  <= op_b_d;
         lt_q    <= lt_d;
         eq_q    <= eq_d;
         gt_q    <= gt_d;
`ifndef ARB_FIXED_PRIORITY_EN
         ptr_q   <= ptr_d;
`endif
      end
   end

   // Outputs decode directly from registered state, so they clear the instant rst rises.
   assign done        = (state_q == S_RES);
   assign busy        = (state_q == S_CMP) || (state_q == S_RES);
   assign grant       = done ? ({{(N_REQ-1){1'b0}}, 1'b1} << win_q) : '0;
   assign lt          = lt_q;
   assign eq          = eq_q;
   assign gt          = gt_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_comparator_arbiter.sv
// Randomized and directed bench for comparator_arbiter against a transaction-level model.
// Build with ARB_FIXED_PRIORITY_EN to check the fixed-priority variant.

module tb_comparator_arbiter;
   localparam int WIDTH = 16;
   localparam int N_REQ = 4;
   localparam int EW    = N_REQ + 3;

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic [N_REQ-1:0]       req = '0;
   logic [N_REQ*WIDTH-1:0] a_flat = '0;
   logic [N_REQ*WIDTH-1:0] b_flat = '0;
   logic [N_REQ-1:0]       grant;
   logic                   done, lt, eq, gt, busy;
   logic [1:0]             dbg_state;

   int n_vec = 0;
   int n_err = 0;

   comparator_arbiter #(.WIDTH(WIDTH), .N_REQ(N_REQ)) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .a_flat      (a_flat),
      .b_flat      (b_flat),
      .grant       (grant),
      .done        (done),
      .lt          (lt),
      .eq          (eq),
      .gt          (gt),
      .busy        (busy),
      .dbg_state_o (dbg_state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: a compare is accepted on any edge at or after free_edge with a
   // request pending; its result appears one edge later and the next accept is 3 edges on.
   logic [EW-1:0] exp_q[$];
   int            due_q[$];
   int            edge_cnt  = 0;
   int            free_edge = 0;
   int            busy_from = 0;
   int            busy_to   = -1;
   int            ptr_m     = 0;
   logic [2:0]    last_res  = 3'b000;

   function automatic int pick_winner(input int p, input logic [N_REQ-1:0] r);
      for (int k = 0; k < N_REQ; k++) begin
         int i;
         i = (p + k) % N_REQ;
         if (r[i]) return i;
      end
      return -1;
   endfunction

   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            exp_q.delete();
            due_q.delete();
            free_edge = 0;
            busy_from = 0;
            busy_to   = -1;
            ptr_m     = 0;
            last_res  = 3'b000;
         end else begin
            edge_cnt++;
            if (edge_cnt >= free_edge && req != '0) begin
               int w;
               logic [WIDTH-1:0] a, b;
               logic [N_REQ-1:0] oh;
               w  = pick_winner(ptr_m, req);
               a  = a_flat[w*WIDTH +: WIDTH];
               b  = b_flat[w*WIDTH +: WIDTH];
               oh = '0;
               oh[w] = 1'b1;
               exp_q.push_back({oh, a < b, a == b, a > b});
               due_q.push_back(edge_cnt + 1);
               busy_from = edge_cnt;
               busy_to   = edge_cnt + 1;
               free_edge = edge_cnt + 3;
`ifdef ARB_FIXED_PRIORITY_EN
               ptr_m = 0;
`else
               ptr_m = (w + 1) % N_REQ;
`endif
            end
         end
      end
   end

   // Monitor: every cycle, compare outputs with the model away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            logic exp_done;
            logic [EW-1:0] e;
            exp_done = (due_q.size() > 0) && (due_q[0] == edge_cnt);
            chk("mon_done", done, exp_done);
            chk("mon_busy", busy, (edge_cnt >= busy_from) && (edge_cnt <= busy_to));
            if (exp_done) begin
               e = exp_q.pop_front();
               void'(due_q.pop_front());
               chk("mon_grant", grant, e[EW-1:3]);
               chk("mon_res", {lt, eq, gt}, e[2:0]);
               last_res = e[2:0];
            end else begin
               chk("mon_grant_idle", grant, '0);
               chk("mon_res_hold", {lt, eq, gt}, last_res);
            end
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      chk(tag, {grant, done, lt, eq, gt, busy, dbg_state}, '0);
   endtask

   task automatic quiesce();
      req = '0;
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!done && lat < 10);
      if (!done) chk("done_timeout", done, 1'b1);
   endtask

   task automatic rand_cycles(input int n);
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         rst = 1'b0;
         if ($urandom_range(0, 3) == 0) req = N_REQ'($urandom_range(0, (1 << N_REQ) - 1));
         for (int i = 0; i < N_REQ; i++) begin
            if ($urandom_range(0, 1) == 1) begin
               a_flat[i*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 3));
               b_flat[i*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 3));
            end else begin
               a_flat[i*WIDTH +: WIDTH] = WIDTH'($urandom);
               b_flat[i*WIDTH +: WIDTH] = WIDTH'($urandom);
            end
         end
         if ($urandom_range(0, 49) == 0) begin
            #2;
            rst = 1'b1;
            #1;
            check_reset_outputs("rand_async_rst");
         end
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      logic [N_REQ-1:0] exp_g;

      repeat (2) @(negedge clk);
      check_reset_outputs("por_outputs");
      rst = 1'b0;

      rand_cycles(200);

      // Async reset mid-run, then round-robin over four equal requesters.
      @(posedge clk);
      req = '1;
      #2;
      rst = 1'b1;
      #1;
      check_reset_outputs("async_rst");
      @(negedge clk);
      rst = 1'b0;
      req = '1;
      for (int i = 0; i < N_REQ; i++) begin
         a_flat[i*WIDTH +: WIDTH] = 16'h0000;
         b_flat[i*WIDTH +: WIDTH] = 16'h0019;
      end
      for (int k = 0; k < 5; k++) begin
         wait_done(lat);
         chk("rr_spacing", lat, (k == 0) ? 2 : 3);
`ifdef ARB_FIXED_PRIORITY_EN
         exp_g = 4'b0001;
`else
         exp_g = N_REQ'(1) << (k % N_REQ);
`endif
         chk("rr_grant", grant, exp_g);
         chk("rr_lt", {lt, eq, gt}, 3'b100);
      end
      quiesce();

      // Single requester: equal, then greater.
      req = 4'b0010;
      a_flat[1*WIDTH +: WIDTH] = 16'h0019;
      b_flat[1*WIDTH +: WIDTH] = 16'h0019;
      wait_done(lat);
      chk("single_latency", lat, 2);
      chk("single_grant_eq", grant, 4'b0010);
      chk("single_eq", {lt, eq, gt}, 3'b010);
      quiesce();
      req = 4'b0010;
      a_flat[1*WIDTH +: WIDTH] = 16'h0025;
      wait_done(lat);
      chk("single_grant_gt", grant, 4'b0010);
      chk("single_gt", {lt, eq, gt}, 3'b001);
      quiesce();

      // Operands latched at grant: later changes and a dropped req do not matter.
      req = 4'b0100;
      a_flat[2*WIDTH +: WIDTH] = 16'h0030;
      b_flat[2*WIDTH +: WIDTH] = 16'h0010;
      @(negedge clk);
      a_flat[2*WIDTH +: WIDTH] = 16'h0005;
      req = '0;
      wait_done(lat);
      chk("latch_latency", lat, 1);
      chk("latch_grant", grant, 4'b0100);
      chk("latch_res", {lt, eq, gt}, 3'b001);
      quiesce();

      // Abort during S_CMP: no done, then a fresh compare works.
      req = 4'b0001;
      a_flat[0 +: WIDTH] = 16'h0000;
      b_flat[0 +: WIDTH] = 16'h0005;
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_reset_outputs("abort_outputs");
      @(negedge clk);
      rst = 1'b0;
      req = '0;
      repeat (3) begin
         @(negedge clk);
         chk("abort_no_done", done, 1'b0);
      end
      req = 4'b0001;
      a_flat[0 +: WIDTH] = 16'hFFFF;
      b_flat[0 +: WIDTH] = 16'h0000;
      wait_done(lat);
      chk("abort_next_grant", grant, 4'b0001);
      chk("abort_next_gt", {lt, eq, gt}, 3'b001);
      quiesce();

`ifdef ARB_FIXED_PRIORITY_EN
      req = 4'b1010;
      for (int k = 0; k < 6; k++) begin
         wait_done(lat);
         chk("fixed_grant", grant, 4'b0010);
      end
      quiesce();
`endif

      rand_cycles(800);
      quiesce();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
